// File: rtl/rgb_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_bank
// Purpose  : Multi-channel RGB LED PWM driver with double-buffered duties,
//            per-channel enable and optional blink.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   wr_en        register write strobe (one cycle)
//   wr_addr      {channel, sel[1:0]}; sel 0=red 1=green 2=blue 3=mode
//   wr_data      duty value; for mode bit0=enable, bit1=blink
//   rd_addr      read address, same map as wr_addr
//   rd_data      registered read data (shadow duty or mode)
//   rgb_led      channel c on bits [3c+2:3c] = {blue, green, red}
//   period_tick  one-cycle pulse after every PWM counter wrap
// Build option
//   RGB_PWM_BLINK_EN  when defined, mode bit1 is stored and enables blink
// ============================================================================
module rgb_pwm_bank #(
  parameter int CH         = 4,
  parameter int PW         = 8,
  parameter int PRESC      = 16,
  parameter int BLINK_LOG2 = 6,
  localparam int AW        = $clog2(CH) + 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [PW-1:0]   wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [PW-1:0]   rd_data,
  output logic [3*CH-1:0] rgb_led,
  output logic            period_tick
);

  localparam int PREW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PREW-1:0] C_PRE_LAST = PREW'(PRESC - 1);

  // --------------------------------------------------------------------------
  // Prescaler and PWM counter
  // --------------------------------------------------------------------------
  logic [PREW-1:0] r_pre;
  logic [PW-1:0]   r_cnt;
  logic            w_step;
  logic            w_wrap;

  assign w_step = (r_pre == C_PRE_LAST);
  // The wrap step is the period boundary: active duties reload here.
  assign w_wrap = w_step && (r_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre       <= '0;
      r_cnt       <= '0;
      period_tick <= 1'b0;
    end else begin
      r_pre       <= w_step ? '0 : r_pre + PREW'(1);
      if (w_step) begin
        r_cnt <= r_cnt + PW'(1);
      end
      period_tick <= w_wrap;
    end
  end

  // --------------------------------------------------------------------------
  // Blink phase
  // --------------------------------------------------------------------------
  logic       w_phase;
  logic [1:0] w_mode_wdata;

`ifdef RGB_PWM_BLINK_EN
  localparam int BW = BLINK_LOG2 + 1;
  // Free-running count of period boundaries; its MSB toggles every
  // 2^BLINK_LOG2 boundaries and serves directly as the blink phase.
  logic [BW-1:0] r_blink_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
    end else if (w_wrap) begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign w_phase      = r_blink_cnt[BLINK_LOG2];
  assign w_mode_wdata = wr_data[1:0];
`else
  assign w_phase      = 1'b0;
  assign w_mode_wdata = {1'b0, wr_data[0]};
`endif

  // --------------------------------------------------------------------------
  // Register file: shadow/active duties and mode
  // --------------------------------------------------------------------------
  logic [PW-1:0] r_shadow [CH][3];
  logic [PW-1:0] r_active [CH][3];
  logic [1:0]    r_mode   [CH];

  // Address decode is by full-address compare per register, so any channel
  // index >= CH simply matches nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        r_mode[c] <= '0;
        for (int k = 0; k < 3; k++) begin
          r_shadow[c][k] <= '0;
          r_active[c][k] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        for (int k = 0; k < 3; k++) begin
          // Non-blocking read of shadow: a write in the boundary cycle is
          // not seen by active until the following boundary.
          if (w_wrap) begin
            r_active[c][k] <= r_shadow[c][k];
          end
          if (wr_en && (wr_addr == AW'(4 * c + k))) begin
            r_shadow[c][k] <= wr_data;
          end
        end
        if (wr_en && (wr_addr == AW'(4 * c + 3))) begin
          r_mode[c] <= w_mode_wdata;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read port
  // --------------------------------------------------------------------------
  logic [PW-1:0] w_rd_val;

  always_comb begin
    w_rd_val = '0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (rd_addr == AW'(4 * c + k)) begin
          w_rd_val = r_shadow[c][k];
        end
      end
      if (rd_addr == AW'(4 * c + 3)) begin
        w_rd_val = PW'(r_mode[c]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= w_rd_val;
    end
  end

  // --------------------------------------------------------------------------
  // LED outputs
  // --------------------------------------------------------------------------
  logic [3*CH-1:0] w_led;

  always_comb begin
    w_led = '0;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < 3; k++) begin
        // All-ones duty is constant on; otherwise cnt < duty (0 = off).
        w_led[3 * c + k] = r_mode[c][0]
                           && !(w_phase && r_mode[c][1])
                           && ((r_cnt < r_active[c][k]) || (r_active[c][k] == '1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_led <= '0;
    end else begin
      rgb_led <= w_led;
    end
  end

endmodule
`default_nettype wire
